// File: rtl/vgaout_pkg.sv
// Shared VGA timing constants, pixel/flag types and colour helpers for the
// vgaout PPU-to-VGA line-doubling scan converter.
package vgaout_pkg;

    localparam logic [9:0] H_ACTIVE   = 10'd640;
    localparam logic [9:0] H_FP       = 10'd16;
    localparam logic [9:0] H_SYNC     = 10'd96;
    localparam logic [9:0] H_TOTAL    = 10'd800;
    localparam logic [9:0] V_ACTIVE   = 10'd480;
    localparam logic [9:0] V_FP       = 10'd10;
    localparam logic [9:0] V_SYNC     = 10'd2;
    localparam logic [9:0] V_TOTAL    = 10'd525;
    localparam logic [9:0] X_OFFSET   = 10'd64;
    localparam logic [9:0] PIC_WIDTH  = 10'd512;
    localparam logic [9:0] LOCK_VLINE = 10'd523;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic blank;
        logic odd;
    } vflags_t;

    function automatic rgb_t halve_rgb(input rgb_t c);
        return {c[23:16] >> 3'd1, c[15:8] >> 3'd1, c[7:0] >> 3'd1};
    endfunction

endpackage

// File: rtl/vgaout_linebuf.sv
// 1024x24 simple dual-port line ring: synchronous write, registered read
// gated by a read enable. Same-address read/write returns the old word.
module vgaout_linebuf
    import vgaout_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  rgb_t       wdata,
    input  logic       re,
    input  logic [9:0] raddr,
    output rgb_t       rdata
);

    rgb_t mem_q [1024];
    rgb_t rdata_q;

    // Storage array and read register; left unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vgaout.sv
// PPU scanline capture into a 4-line ring, replayed as a frame-locked 640x480
// VGA raster with 2x2 pixels. Define VGAOUT_SCANLINE_EN to darken odd lines.
module vgaout
    import vgaout_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pxvalid,
    input  logic [8:0]  outx,
    input  logic [8:0]  outy,
    input  logic [23:0] pix,
    input  logic        vtick,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        locked
);

`ifdef VGAOUT_SCANLINE_EN
    localparam logic SCANLINE_EN = 1'b1;
`else
    localparam logic SCANLINE_EN = 1'b0;
`endif

    localparam vflags_t FLAGS_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, blank: 1'b1, odd: 1'b0};

    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic       locked_q, locked_d;
    vflags_t    s1_q, s1_d, s1_next_s;
    rgb_t       rgb_q, rgb_d, rgb_next_s;
    logic       hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic       lock_ev_s;
    logic [7:0] col_s;
    rgb_t       rd_pix_s;

    vgaout_linebuf u_linebuf (
        .clk   (clk),
        .we    (pxvalid & ~outx[8]),
        .waddr ({outy[1:0], outx[7:0]}),
        .wdata (pix),
        .re    (vtick),
        .raddr ({vcnt_q[2:1], col_s}),
        .rdata (rd_pix_s)
    );

    // Raster counters with PPU frame lock; a lock event beats the vtick increment
    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        locked_d  = locked_q;
        lock_ev_s = pxvalid && (outx == 9'd0) && (outy == 9'd0)
                    && ((vcnt_q >= V_ACTIVE) || !locked_q);
        if (lock_ev_s) begin
            hcnt_d   = 10'd0;
            vcnt_d   = LOCK_VLINE;
            locked_d = 1'b1;
        end else if (vtick) begin
            if (hcnt_q == H_TOTAL - 10'd1) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == V_TOTAL - 10'd1) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // Stage 1: ring read address and raster flags for the current dot
    always_comb begin
        col_s           = hcnt_q[8:1] - X_OFFSET[8:1];
        s1_next_s.hs    = !((hcnt_q >= H_ACTIVE + H_FP) && (hcnt_q < H_ACTIVE + H_FP + H_SYNC));
        s1_next_s.vs    = !((vcnt_q >= V_ACTIVE + V_FP) && (vcnt_q < V_ACTIVE + V_FP + V_SYNC));
        s1_next_s.de    = (hcnt_q < H_ACTIVE) && (vcnt_q < V_ACTIVE);
        s1_next_s.blank = !(locked_q && (hcnt_q >= X_OFFSET) && (hcnt_q < X_OFFSET + PIC_WIDTH));
        s1_next_s.odd   = vcnt_q[0];
        if (vtick) begin
            s1_d = s1_next_s;
        end else begin
            s1_d = s1_q;
        end
    end

    // Stage 2: colour select, optional scanline dimming, output hold between dots
    always_comb begin
        rgb_next_s = 24'h000000;
        if (s1_q.de && !s1_q.blank) begin
            rgb_next_s = (SCANLINE_EN && s1_q.odd) ? halve_rgb(rd_pix_s) : rd_pix_s;
        end else begin
            rgb_next_s = 24'h000000;
        end
        if (vtick) begin
            rgb_d = rgb_next_s;
            hs_d  = s1_q.hs;
            vs_d  = s1_q.vs;
            de_d  = s1_q.de;
        end else begin
            rgb_d = rgb_q;
            hs_d  = hs_q;
            vs_d  = vs_q;
            de_d  = de_q;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q   <= 10'd0;
            vcnt_q   <= 10'd0;
            locked_q <= 1'b0;
            s1_q     <= FLAGS_RST;
            rgb_q    <= 24'h000000;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            locked_q <= locked_d;
            s1_q     <= s1_d;
            rgb_q    <= rgb_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
        end
    end

    assign vga_r  = rgb_q[23:16];
    assign vga_g  = rgb_q[15:8];
    assign vga_b  = rgb_q[7:0];
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;
    assign vga_de = de_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_vgaout.sv
// Scoreboard bench for vgaout: expectations are tagged with the vtick count at
// which they fall due and checked by an independent monitor process.
module tb_vgaout;

    logic        clk = 1'b0;
    logic        reset;
    logic        pxvalid;
    logic [8:0]  outx;
    logic [8:0]  outy;
    logic [23:0] pix;
    logic        vtick;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, locked;

    localparam int L      = 1500;      // vtick edge carrying the first frame start
    localparam int F      = L + 3301;  // second frame start, VGA line 2 dot 100
    localparam int RST_AT = L + 5100;  // mid-active reset, VGA line 4

`ifdef VGAOUT_SCANLINE_EN
    localparam logic [23:0] L1_66 = 24'h000000, L1_68 = 24'h010101;
    localparam logic [23:0] L1_572 = 24'h7F7F7F, L1_575 = 24'h7F7F7F;
`else
    localparam logic [23:0] L1_66 = 24'h010101, L1_68 = 24'h020202;
    localparam logic [23:0] L1_572 = 24'hFEFEFE, L1_575 = 24'hFFFFFF;
`endif

    typedef struct {
        int          tag;
        string       name;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic        lk;
    } exp_t;

    exp_t sb_q[$];
    int   ecnt   = 0;
    int   checks = 0;
    int   errors = 0;
    int   base;

    vgaout dut (
        .clk    (clk),
        .reset  (reset),
        .pxvalid(pxvalid),
        .outx   (outx),
        .outy   (outy),
        .pix    (pix),
        .vtick  (vtick),
        .vga_r  (vga_r),
        .vga_g  (vga_g),
        .vga_b  (vga_b),
        .vga_hs (vga_hs),
        .vga_vs (vga_vs),
        .vga_de (vga_de),
        .locked (locked)
    );

    always #5 clk = ~clk;

    task automatic push(input int tag, input string name, input logic hs, input logic vs,
                        input logic de, input logic [23:0] rgb, input logic lk);
        exp_t e;
        e.tag = tag; e.name = name; e.hs = hs; e.vs = vs; e.de = de; e.rgb = rgb; e.lk = lk;
        sb_q.push_back(e);
    endtask

    task automatic compare_exp(input exp_t e);
        checks++;
        if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, locked} !== {e.hs, e.vs, e.de, e.rgb, e.lk}) begin
            errors++;
            $display("FAIL %s tag=%0d got hs=%b vs=%b de=%b rgb=%06h locked=%b, expected hs=%b vs=%b de=%b rgb=%06h locked=%b",
                     e.name, e.tag, vga_hs, vga_vs, vga_de, {vga_r, vga_g, vga_b}, locked,
                     e.hs, e.vs, e.de, e.rgb, e.lk);
        end
    endtask

    task automatic check_now(input string name, input logic hs, input logic vs, input logic de,
                             input logic [23:0] rgb, input logic lk);
        exp_t e;
        e.tag = -1; e.name = name; e.hs = hs; e.vs = vs; e.de = de; e.rgb = rgb; e.lk = lk;
        compare_exp(e);
    endtask

    task automatic wait_ecnt(input int n);
        int guard = 0;
        while (ecnt < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt < n) begin
            checks++;
            errors++;
            $display("FAIL wait_ecnt got=%0d expected=%0d", ecnt, n);
        end
    endtask

    // Monitor: count vtick edges out of reset, compare entries as they fall due
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset === 1'b1 && vtick === 1'b1) ecnt++;
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].tag <= ecnt) begin
                e = sb_q.pop_front();
                if (e.tag < ecnt) begin
                    checks++;
                    errors++;
                    $display("FAIL %s missed tag=%0d got ecnt=%0d", e.name, e.tag, ecnt);
                end else begin
                    compare_exp(e);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; vtick = 1'b1; pxvalid = 1'b0; outx = 9'd0; outy = 9'd0; pix = 24'h0;
        repeat (3) @(negedge clk);
        check_now("rst_state", 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0);
        reset = 1'b1;

        // Free-running, unlocked: output for raster position p appears at tag p+2
        push(2,    "a_h0",    1'b1, 1'b1, 1'b1, 24'h0, 1'b0);
        push(641,  "a_h639",  1'b1, 1'b1, 1'b1, 24'h0, 1'b0);
        push(642,  "a_h640",  1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
        push(657,  "a_h655",  1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
        push(658,  "a_h656",  1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
        push(753,  "a_h751",  1'b0, 1'b1, 1'b0, 24'h0, 1'b0);
        push(754,  "a_h752",  1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
        push(1102, "a_v1h300", 1'b1, 1'b1, 1'b1, 24'h0, 1'b0);
        // After lock: j=0 is (h0,v523) at tag L+2; VGA line k dot h at L+1602+800k+h
        push(L + 2,    "lock_j0",   1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
        push(L + 658,  "lock_hs",   1'b0, 1'b1, 1'b0, 24'h0, 1'b1);
        push(L + 1601, "lock_j1599", 1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
        push(L + 1602, "l0_h0",     1'b1, 1'b1, 1'b1, 24'h0, 1'b1);
        push(L + 1665, "l0_h63",    1'b1, 1'b1, 1'b1, 24'h0, 1'b1);
        push(L + 1666, "l0_h64",    1'b1, 1'b1, 1'b1, 24'h000000, 1'b1);
        push(L + 1667, "l0_h65",    1'b1, 1'b1, 1'b1, 24'h000000, 1'b1);
        push(L + 1668, "l0_h66",    1'b1, 1'b1, 1'b1, 24'h010101, 1'b1);
        push(L + 1669, "l0_h67",    1'b1, 1'b1, 1'b1, 24'h010101, 1'b1);
        push(L + 1670, "l0_h68",    1'b1, 1'b1, 1'b1, 24'h020202, 1'b1);
        push(L + 2174, "l0_h572",   1'b1, 1'b1, 1'b1, 24'hFEFEFE, 1'b1);
        push(L + 2177, "l0_h575",   1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b1);
        push(L + 2178, "l0_h576",   1'b1, 1'b1, 1'b1, 24'h0, 1'b1);
        push(L + 2241, "l0_h639",   1'b1, 1'b1, 1'b1, 24'h0, 1'b1);
        push(L + 2242, "l0_h640",   1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
        push(L + 2468, "l1_h66",    1'b1, 1'b1, 1'b1, L1_66, 1'b1);
        push(L + 2470, "l1_h68",    1'b1, 1'b1, 1'b1, L1_68, 1'b1);
        push(L + 2974, "l1_h572",   1'b1, 1'b1, 1'b1, L1_572, 1'b1);
        push(L + 2977, "l1_h575",   1'b1, 1'b1, 1'b1, L1_575, 1'b1);
        // Line 3, after the ignored second frame start
        push(L + 4641, "l3_h639",   1'b1, 1'b1, 1'b1, 24'h0, 1'b1);
        push(L + 4642, "l3_h640",   1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
        push(L + 4657, "l3_h655",   1'b1, 1'b1, 1'b0, 24'h0, 1'b1);
        push(L + 4658, "l3_h656",   1'b0, 1'b1, 1'b0, 24'h0, 1'b1);

        // Frame start plus PPU line 0 fill, pixel x sampled on edge L+x
        wait_ecnt(L - 1);
        pxvalid = 1'b1; outx = 9'd0; outy = 9'd0; pix = 24'h000000;
        for (int x = 1; x < 256; x++) begin
            @(negedge clk);
            outx = 9'(x);
            pix  = 24'(x) * 24'h010101;
        end
        @(negedge clk);
        pxvalid = 1'b0;
        // Dot-enable gap: counters and outputs hold, tags stay aligned
        vtick = 1'b0;
        repeat (7) @(negedge clk);
        vtick = 1'b1;

        wait_ecnt(F - 1);
        pxvalid = 1'b1; outx = 9'd0; outy = 9'd0; pix = 24'h123456;
        @(negedge clk);
        pxvalid = 1'b0;

        wait_ecnt(RST_AT);
        #2 reset = 1'b0;
        #1 check_now("rst_async", 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        base = ecnt;
        push(base + 2,   "r_h0",   1'b1, 1'b1, 1'b1, 24'h0, 1'b0);
        push(base + 302, "r_h300", 1'b1, 1'b1, 1'b1, 24'h0, 1'b0);
        push(base + 642, "r_h640", 1'b1, 1'b1, 1'b0, 24'h0, 1'b0);
        push(base + 658, "r_h656", 1'b0, 1'b1, 1'b0, 24'h0, 1'b0);

        wait_ecnt(base + 700);
        repeat (2) @(negedge clk);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s unchecked tag=%0d got ecnt=%0d", e.name, e.tag, ecnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vgaout.md
# vgaout

Pixel-stream receiver for the PPU video output. It captures each rendered 256-pixel NES scanline into a 4-line ring buffer and replays it as a 640x480 VGA raster. Each NES pixel becomes a 2x2 block, giving a 512x480 picture centred with 64-pixel black side borders. The block sits between the PPU pixel outputs (outx/outy/pxvalid/pix) and the board video DAC/encoder, and frame-locks its VGA timing to the PPU so no frame buffer is needed.

## Interface
Parameters:
- none; timing constants come from the shared package.

Ports:
- clk  in  1  system clock, same as PPU clk
- reset  in  1  asynchronous, active-low (0 = reset)
- pxvalid  in  1  PPU pixel strobe, already qualified by the PPU tick
- outx  in  9  PPU pixel x, 0..255 when pxvalid
- outy  in  9  PPU pixel y, 0..239 when pxvalid
- pix  in  24  PPU pixel RGB {R,G,B}
- vtick  in  1  VGA pixel enable, one clk pulse per VGA dot (~25.175 MHz rate)
- vga_r, vga_g, vga_b  out  8 each  output colour
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_de  out  1  data enable, high in the 640x480 active area
- locked  out  1  set by the first PPU frame start; cleared only by reset

## Operation
Write side:
- On every clk with pxvalid and outx<256, write pix to ring address {outy[1:0], outx[7:0]}.
- Pixels with outx>=256 are dropped.
- Writes are independent of vtick.

VGA counters:
- hcnt 0..799 and vcnt 0..524; both advance only on vtick.
- hcnt wraps 799->0 and increments vcnt; vcnt wraps 524->0.
- Active area: hcnt<640 && vcnt<480.
- hs low for hcnt 656..751; vs low for vcnt 490..491.

Frame lock:
- A PPU frame start is pxvalid && outx==0 && outy==0.
- If vcnt>=480 or locked==0: hcnt<=0, vcnt<=523, locked<=1.
- If vcnt<480 and locked==1: the event is ignored and the counters free-run. Drift is at most a few lines per frame, so this does not occur in steady state.
- Resulting alignment: VGA line 0 starts one NES line after PPU line 0 starts. VGA line pair 2k,2k+1 reads ring line k[1:0] while the PPU writes k+1, so there is no read/write collision.

Read side:
- Active columns hcnt 64..575 read address {vcnt[2:1], (hcnt-64)[8:1]}.
- Columns hcnt<64 and 576..639 output black with vga_de=1.
- Before locked=1 the whole active area is black.
- Same-address read/write in one cycle returns the old data (read-before-write).

## Timing
- Reset values: hcnt=0, vcnt=0, locked=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_de=0, all pipeline registers cleared.
- Reset deassertion mid-frame restarts free-running at hcnt=vcnt=0. Lock is reacquired at the next PPU frame start.
- Pipeline is 2 vticks:
  - Stage 1 (vtick): RAM read issued; hs/vs/de/border/scanline flags registered.
  - Stage 2 (next vtick): vga_* outputs registered.
- hs, vs and de are delayed identically to the colour, so they stay aligned to it.
- Outputs change only on clk edges where vtick=1.
- A lock event on the same clk as a vtick overrides the counter increment.
- RAM write has 1-clk latency. Data written by pxvalid is readable by any later read.

## Configuration
- VGAOUT_SCANLINE_EN:
  - Defined: on odd vcnt, each colour channel is halved (logical shift right by 1) before the output register, giving CRT-style scanlines.
  - Undefined: odd lines are identical to even lines.
- sync, de and latency are unaffected by the macro.

## Structure
- Shared package holds:
  - H_ACTIVE=640, H_FP=16, H_SYNC=96, H_TOTAL=800
  - V_ACTIVE=480, V_FP=10, V_SYNC=2, V_TOTAL=525
  - X_OFFSET=64, LOCK_VLINE=523
  - the RGB pixel type (24-bit)
- One sub-module: vgaout_linebuf, a 1024x24 simple dual-port RAM with synchronous write and a read port registered on a read enable (vtick). It must be inferable as block RAM.

## Test plan
- Reset held low, then released, vtick every clk, no pixels -> hs period 800 vticks with 96 low; vs low for 2 lines every 525; de high 640 of 800; rgb=0; locked=0.
- PPU frame start at vcnt=300 -> hcnt=0, vcnt=523 next clk; locked=1; VGA line 0 active starts 1600 vticks later.
- PPU line 0 filled with pix=x*0x010101, then lock -> VGA line 0 at hcnt 64,65 shows 0x000000; hcnt 66,67 shows 0x010101; hcnt 575 shows 0xFFFFFF; hcnt 0..63 black with de=1.
- Second frame start at vcnt=100 while locked -> counters unaffected; locked stays 1.
- VGAOUT_SCANLINE_EN defined, pix=0xFEFEFE on line 0 -> VGA line 0 shows 0xFEFEFE; line 1 shows 0x7F7F7F. Undefined -> both lines 0xFEFEFE.
- reset asserted mid-active-line -> vga_hs=1, vga_vs=1, vga_de=0, rgb=0 immediately without a clk edge; locked=0.
